// File: rtl/fc_pe_ctrl_pkg.sv
// Types and constants shared by the fc_pe_ctrl sources.
`include "incl.vh"

package fc_pe_ctrl_pkg;

    // Job sequencer states; encodings come from the shared header.
    typedef enum logic [1:0] {
        ST_IDLE  = `FC_PE_ST_IDLE,
        ST_RUN   = `FC_PE_ST_RUN,
        ST_DRAIN = `FC_PE_ST_DRAIN,
        ST_DONE  = `FC_PE_ST_DONE
    } state_t;

    // Activation / weight element width.
    localparam int ELEM_W = 9;
    // Number of tile flags carried alongside each beat.
    localparam int FLAG_W = 3;

endpackage

// File: rtl/fc_pe_ctrl_perf.sv
// Saturating busy / stall cycle counters for fc_pe_ctrl.
// Only present when FC_PE_CTRL_PERF_EN is defined.
`ifdef FC_PE_CTRL_PERF_EN
module fc_pe_ctrl_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        busy_in,
    input  logic        stall_in,
    output logic [31:0] busy_cyc,
    output logic [31:0] stall_cyc
);

    // Count qualifying cycles, holding at all-ones; a job start clears both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cyc  <= '0;
            stall_cyc <= '0;
        end else if (clr) begin
            busy_cyc  <= '0;
            stall_cyc <= '0;
        end else begin
            if (busy_in && (busy_cyc != '1))   busy_cyc  <= busy_cyc + 32'd1;
            if (stall_in && (stall_cyc != '1)) stall_cyc <= stall_cyc + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/incl.vh
// Shared header: platform width macros and the fc_pe_ctrl state encodings.
`ifndef FC_INCL_VH
`define FC_INCL_VH

// Width of the DDR AXI-stream data path; one byte of it per PE column.
`define DDR_AXIS_DATA_WIDTH 64

// fc_pe_ctrl FSM state encodings.
`define FC_PE_ST_IDLE  2'd0
`define FC_PE_ST_RUN   2'd1
`define FC_PE_ST_DRAIN 2'd2
`define FC_PE_ST_DONE  2'd3

`endif

// File: rtl/shift_reg.sv
// Fixed-depth delay line with asynchronous clear of every stage.
module shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift din through DEPTH registers; reset empties the whole line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fc_pe_ctrl.sv
// Fully-connected layer PE controller: streams n_x weight beats per tile for
// n_tiles tiles, reads the matching activation from the x-buffer and presents
// both, with tile flags, to the PE array two cycles after each accepted beat.
// Optional FC_PE_CTRL_PERF_EN adds perf_busy_cyc / perf_stall_cyc counters.
`include "incl.vh"

module fc_pe_ctrl
    import fc_pe_ctrl_pkg::*;
#(
    parameter int PE_NUM = `DDR_AXIS_DATA_WIDTH / 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_n_x,
    input  logic [CNT_W-1:0]         cfg_n_tiles,
    output logic                     busy,
    output logic                     done,
    input  logic [PE_NUM*ELEM_W-1:0] w_data,
    input  logic                     w_valid,
    output logic                     w_ready,
    output logic                     x_rd_en,
    output logic [CNT_W-1:0]         x_rd_addr,
    input  logic [ELEM_W-1:0]        x_rd_data,
    output logic [ELEM_W-1:0]        mat_x,
    output logic [PE_NUM*ELEM_W-1:0] mat_w,
    output logic                     mat_begin,
    output logic                     mat_end,
    output logic                     mat_end_last,
    input  logic                     mat_y_last
`ifdef FC_PE_CTRL_PERF_EN
    ,
    output logic [31:0]              perf_busy_cyc,
    output logic [31:0]              perf_stall_cyc
`endif
);

    // Weight handshake: a beat transfers in every cycle where w_valid && w_ready.
    // The source holds w_data stable while w_valid is high and w_ready is low;
    // w_ready is high for the whole RUN state and never depends on w_valid.

    localparam int PIPE_W = FLAG_W + PE_NUM * ELEM_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   k, t, n_x_q, n_tiles_q;
    logic               start_ok, hs, first_k, last_k, last_t, x_vld;
    logic [PIPE_W-1:0]  pipe_in, pipe_out;

    assign start_ok = start && (state == ST_IDLE);
    assign hs       = w_valid && (state == ST_RUN);
    assign first_k  = (k == '0);
    assign last_k   = (k == n_x_q - CNT_ONE);
    assign last_t   = (t == n_tiles_q - CNT_ONE);

    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign w_ready   = (state == ST_RUN);
    assign x_rd_en   = hs;
    assign x_rd_addr = k;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a zero-sized job skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if ((cfg_n_x != '0) && (cfg_n_tiles != '0)) state_nxt = ST_RUN;
                    else                                        state_nxt = ST_DONE;
                end
            end
            ST_RUN:   if (hs && last_k && last_t) state_nxt = ST_DRAIN;
            ST_DRAIN: if (mat_y_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latch the job size on start and walk beat/tile indices per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            t         <= '0;
            n_x_q     <= '0;
            n_tiles_q <= '0;
        end else if (start_ok) begin
            k         <= '0;
            t         <= '0;
            n_x_q     <= cfg_n_x;
            n_tiles_q <= cfg_n_tiles;
        end else if (hs) begin
            if (last_k) begin
                k <= '0;
                t <= t + CNT_ONE;
            end else begin
                k <= k + CNT_ONE;
            end
        end
    end

    // Beat payload for the PE array; zeros form a harmless bubble on stalls.
    always_comb begin
        pipe_in = '0;
        if (hs) pipe_in = {first_k, last_k, last_k && last_t, w_data};
    end

    // Two register stages line weights and flags up with the x-buffer read.
    shift_reg #(.WIDTH(PIPE_W), .DEPTH(2)) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  (pipe_in),
        .dout (pipe_out)
    );

    // Marks the cycle in which x_rd_data carries a requested activation.
    shift_reg #(.WIDTH(1), .DEPTH(1)) u_x_vld (
        .clk  (clk),
        .rst  (rst),
        .din  (hs),
        .dout (x_vld)
    );

    assign {mat_begin, mat_end, mat_end_last, mat_w} = pipe_out;

    // Register the activation only when it belongs to an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        mat_x <= '0;
        else if (x_vld) mat_x <= x_rd_data;
        else            mat_x <= '0;
    end

`ifdef FC_PE_CTRL_PERF_EN
    fc_pe_ctrl_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .busy_in   (busy),
        .stall_in  ((state == ST_RUN) && !w_valid),
        .busy_cyc  (perf_busy_cyc),
        .stall_cyc (perf_stall_cyc)
    );
`endif

endmodule

// File: tb/tb_fc_pe_ctrl.sv
// Self-checking bench for fc_pe_ctrl with an index-based reference model.
module tb_fc_pe_ctrl;

    localparam int PE    = 8;
    localparam int CW    = 16;
    localparam int WW    = PE * 9;
    localparam int RW    = 9 + WW + 3;
    localparam int Y_LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [CW-1:0] cfg_n_x = '0, cfg_n_tiles = '0;
    logic          busy, done, w_ready, x_rd_en;
    logic [WW-1:0] w_data = '0;
    logic          w_valid = 1'b0;
    logic [CW-1:0] x_rd_addr;
    logic [8:0]    x_rd_data = '0;
    logic [8:0]    mat_x;
    logic [WW-1:0] mat_w;
    logic          mat_begin, mat_end, mat_end_last;
    logic          mat_y_last;
    logic          y_auto = 1'b0, y_force = 1'b0;
`ifdef FC_PE_CTRL_PERF_EN
    logic [31:0]   perf_busy_cyc, perf_stall_cyc;
`endif

    assign mat_y_last = y_auto | y_force;

    fc_pe_ctrl #(.PE_NUM(PE), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_n_x      (cfg_n_x),
        .cfg_n_tiles  (cfg_n_tiles),
        .busy         (busy),
        .done         (done),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .x_rd_en      (x_rd_en),
        .x_rd_addr    (x_rd_addr),
        .x_rd_data    (x_rd_data),
        .mat_x        (mat_x),
        .mat_w        (mat_w),
        .mat_begin    (mat_begin),
        .mat_end      (mat_end),
        .mat_end_last (mat_end_last),
        .mat_y_last   (mat_y_last)
`ifdef FC_PE_CTRL_PERF_EN
        ,
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_idx = 0, job_nx = 0, job_nt = 0;
    int n_begin = 0, n_end = 0, n_last = 0;
    int y_at = -1;
    logic          xr_pend = 1'b0;
    logic [CW-1:0] xr_addr = '0;
    logic [8:0]    xmem [256];

    logic [RW-1:0] exp_q [$];
    int            due_q [$];

    // x-buffer model: data is valid exactly one cycle after the read request.
    always @(posedge clk) begin
        #1;
        if (xr_pend) x_rd_data = xmem[xr_addr[7:0]];
        else         x_rd_data = 9'($urandom);
    end

    // Scoreboard: every handshake j predicts one mat_* word two cycles later;
    // every other cycle must show an all-zero bubble.
    always @(negedge clk) begin
        logic [RW-1:0] act, exp_r;
        int j, a;
        #2;
        cyc++;
        y_auto = (cyc == y_at);
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            y_at    = -1;
            y_auto  = 1'b0;
            xr_pend = 1'b0;
        end else begin
            act = {mat_x, mat_w, mat_begin, mat_end, mat_end_last};
            exp_r = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_r = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            checks++;
            if (act !== exp_r) begin
                errors++;
                $display("FAIL mat_out cyc=%0d got=%h exp=%h", cyc, act, exp_r);
            end
            n_begin += int'(mat_begin);
            n_end   += int'(mat_end);
            n_last  += int'(mat_end_last);
            if (mat_end_last === 1'b1) y_at = cyc + Y_LAT;
            xr_pend = 1'b0;
            if (w_valid && w_ready) begin
                j = hs_idx;
                a = (job_nx > 0) ? (j % job_nx) : 0;
                checks++;
                if (x_rd_en !== 1'b1 || x_rd_addr !== CW'(a)) begin
                    errors++;
                    $display("FAIL rd_addr hs=%0d got_en=%b got=%0d exp=%0d", j, x_rd_en, x_rd_addr, a);
                end
                exp_q.push_back({xmem[a], w_data, a == 0, a == job_nx - 1,
                                 j == job_nx * job_nt - 1});
                due_q.push_back(cyc + 2);
                xr_pend = 1'b1;
                xr_addr = x_rd_addr;
                hs_idx++;
            end else begin
                checks++;
                if (x_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_en_idle cyc=%0d got=%b exp=0", cyc, x_rd_en);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Runs one job. start_at / y_at_c pulse start or mat_y_last on that loop
    // cycle (0 = never). Returns busy cycles seen, stall cycles driven, the
    // number of edges from start to done (-1 on timeout) and done one cycle later.
    task automatic run_job(input int nx, input int nt, input int stall_at,
                           input int stall_len, input int rnd, input int start_at,
                           input int y_at_c, output int busy_c, output int stall_c,
                           output int lat, output logic done_after);
        int stalled;
        logic wv;
        logic [95:0] rw;
        busy_c = 0; stall_c = 0; lat = -1; stalled = 0; done_after = 1'bx;
        @(negedge clk);
        for (int i = 0; i < 256; i++) xmem[i] = 9'($urandom);
        job_nx = nx; job_nt = nt; hs_idx = 0;
        n_begin = 0; n_end = 0; n_last = 0;
        cfg_n_x = CW'(nx); cfg_n_tiles = CW'(nt);
        start = 1'b1; w_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cfg_n_x = CW'($urandom); cfg_n_tiles = CW'($urandom);
        for (int c = 1; c <= 3000; c++) begin
            start = (c == start_at);
            y_force = (c == y_at_c);
            if (busy) busy_c++;
            if (done) begin
                lat = c;
                start = 1'b0;
                break;
            end
            if (stall_len > 0 && hs_idx == stall_at + 1 && stalled < stall_len) begin
                wv = 1'b0;
                stalled++;
            end else if (rnd != 0) begin
                wv = ($urandom_range(0, 3) != 0);
            end else begin
                wv = 1'b1;
            end
            if (!wv && w_ready) stall_c++;
            rw = {$urandom, $urandom, $urandom};
            w_valid = wv;
            w_data = rw[WW-1:0];
            @(negedge clk);
        end
        start = 1'b0; y_force = 1'b0; w_valid = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            done_after = done;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #3;
        checks++;
        if ({busy, done, w_ready, x_rd_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, w_ready, x_rd_en});
        end
        checks++;
        if (x_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr got=%0d exp=0", x_rd_addr);
        end
        checks++;
        if ({mat_x, mat_w, mat_begin, mat_end, mat_end_last} !== '0) begin
            errors++;
            $display("FAIL reset_mat got=%h exp=0", {mat_x, mat_w, mat_begin, mat_end, mat_end_last});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int bc, sc, lat;
        logic da;
        // Start pulse on loop cycle 3 and mat_y_last on cycle 2 land in RUN.
        run_job(4, 2, -1, 0, 0, 3, 2, bc, sc, lat, da);
        checks++;
        if (lat < 0) begin errors++; $display("FAIL basic_done got=timeout exp=done"); end
        checks++;
        if (hs_idx !== 8) begin errors++; $display("FAIL basic_hs got=%0d exp=8", hs_idx); end
        checks++;
        if ({n_begin, n_end, n_last} !== {32'd2, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL basic_flags got=%0d/%0d/%0d exp=2/2/1", n_begin, n_end, n_last);
        end
        checks++;
        if (bc !== 8 + sc + Y_LAT + 2) begin
            errors++;
            $display("FAIL basic_busy got=%0d exp=%0d", bc, 8 + sc + Y_LAT + 2);
        end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", da); end
    endtask

    task automatic test_single_beat;
        int bc, sc, lat;
        logic da;
        run_job(1, 3, -1, 0, 0, 0, 0, bc, sc, lat, da);
        checks++;
        if (hs_idx !== 3 || lat < 0) begin
            errors++;
            $display("FAIL single_hs got=%0d lat=%0d exp=3", hs_idx, lat);
        end
        checks++;
        if ({n_begin, n_end, n_last} !== {32'd3, 32'd3, 32'd1}) begin
            errors++;
            $display("FAIL single_flags got=%0d/%0d/%0d exp=3/3/1", n_begin, n_end, n_last);
        end
    endtask

    task automatic test_stall;
        int bc, sc, lat;
        logic da;
        run_job(5, 1, 2, 3, 0, 0, 0, bc, sc, lat, da);
        checks++;
        if (sc !== 3 || hs_idx !== 5 || lat < 0) begin
            errors++;
            $display("FAIL stall_cnt got=%0d hs=%0d lat=%0d exp=3/5", sc, hs_idx, lat);
        end
        checks++;
        if (bc !== 5 + 3 + Y_LAT + 2) begin
            errors++;
            $display("FAIL stall_busy got=%0d exp=%0d", bc, 5 + 3 + Y_LAT + 2);
        end
        checks++;
        if (n_end !== 1 || n_last !== 1) begin
            errors++;
            $display("FAIL stall_end got=%0d/%0d exp=1/1", n_end, n_last);
        end
`ifdef FC_PE_CTRL_PERF_EN
        checks++;
        if (perf_stall_cyc !== 32'd3 || perf_busy_cyc !== 32'(bc)) begin
            errors++;
            $display("FAIL perf got=%0d/%0d exp=3/%0d", perf_stall_cyc, perf_busy_cyc, bc);
        end
`endif
    endtask

    task automatic test_zero_job;
        int bc, sc, lat;
        logic da;
        int sizes [2][2] = '{'{4, 0}, '{0, 3}};
        for (int i = 0; i < 2; i++) begin
            run_job(sizes[i][0], sizes[i][1], -1, 0, 0, 0, 0, bc, sc, lat, da);
            // DONE is entered on the same edge that samples start.
            checks++;
            if (lat !== 1 || hs_idx !== 0 || bc !== 0) begin
                errors++;
                $display("FAIL zero_job%0d lat=%0d hs=%0d busy=%0d exp=1/0/0", i, lat, hs_idx, bc);
            end
            checks++;
            if (da !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got=%b exp=0", da); end
        end
    endtask

    task automatic test_y_last_idle;
        @(negedge clk);
        y_force = 1'b1;
        @(negedge clk);
        y_force = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL y_last_idle got=%b%b exp=00", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL y_last_idle2 got=%b exp=0", done); end
    endtask

    task automatic test_reset_mid;
        int bc, sc, lat, seen;
        logic da;
        @(negedge clk);
        job_nx = 5; job_nt = 2; hs_idx = 0;
        cfg_n_x = 16'd5; cfg_n_tiles = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; w_valid = 1'b1;
        for (int c = 0; c < 20 && hs_idx < 3; c++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, w_ready, x_rd_en, x_rd_addr, mat_x, mat_w, mat_begin, mat_end, mat_end_last} !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%b%b%b%b addr=%0d mat=%h exp=all zero", busy, done, w_ready,
                     x_rd_en, x_rd_addr, {mat_x, mat_w, mat_begin, mat_end, mat_end_last});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen += int'(mat_end) + int'(done) + int'(busy);
        end
        w_valid = 1'b0;
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_abandon got=%0d exp=0", seen); end
        run_job(3, 2, -1, 0, 0, 0, 0, bc, sc, lat, da);
        checks++;
        if (hs_idx !== 6 || n_last !== 1 || lat < 0) begin
            errors++;
            $display("FAIL reset_restart hs=%0d last=%0d lat=%0d exp=6/1", hs_idx, n_last, lat);
        end
    endtask

    task automatic test_random_jobs;
        int bc, sc, lat, nx, nt;
        logic da;
        for (int i = 0; i < 6; i++) begin
            nx = $urandom_range(1, 6);
            nt = $urandom_range(1, 4);
            run_job(nx, nt, -1, 0, 1, 0, 0, bc, sc, lat, da);
            checks++;
            if (lat < 0 || hs_idx !== nx * nt) begin
                errors++;
                $display("FAIL rand_hs job=%0d got=%0d lat=%0d exp=%0d", i, hs_idx, lat, nx * nt);
            end
            checks++;
            if ({n_begin, n_end, n_last} !== {nt, nt, 32'd1}) begin
                errors++;
                $display("FAIL rand_flags job=%0d got=%0d/%0d/%0d exp=%0d/%0d/1", i, n_begin, n_end, n_last, nt, nt);
            end
            checks++;
            if (bc !== nx * nt + sc + Y_LAT + 2) begin
                errors++;
                $display("FAIL rand_busy job=%0d got=%0d exp=%0d", i, bc, nx * nt + sc + Y_LAT + 2);
            end
`ifdef FC_PE_CTRL_PERF_EN
            checks++;
            if (perf_stall_cyc !== 32'(sc) || perf_busy_cyc !== 32'(bc)) begin
                errors++;
                $display("FAIL rand_perf job=%0d got=%0d/%0d exp=%0d/%0d", i, perf_stall_cyc, perf_busy_cyc, sc, bc);
            end
`endif
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_single_beat();
        test_stall();
        test_zero_job();
        test_y_last_idle();
        test_reset_mid();
        test_random_jobs();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
